fractal_param_sequencer: RTL and testbench

FRACTAL_PARAM_SEQUENCER -- requirements
Module: fractal_param_sequencer

---
 rtl/fractal_param_sequencer_pkg.sv | 45 ++++
 rtl/fractal_param_sequencer_if.sv | 12 +
 rtl/fractal_anim_step.sv | 39 +++
 rtl/fractal_param_sequencer.sv | 146 ++++++++++++++
 tb/tb_fractal_param_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fractal_param_sequencer_pkg.sv
// Shared types and constants for the fractal parameter sequencer:
// Q4.28 fixed-point type, the full parameter set struct, its power-on
// value, and the sequencer state encoding.
package fractal_pkg;

    localparam int FRAC_BITS = 28;

    typedef logic signed [31:0] fixed_t;

    typedef struct packed {
        logic [15:0] width;
        logic [15:0] height;
        fixed_t      cr;
        fixed_t      ci;
        fixed_t      dx;
        fixed_t      dy;
        fixed_t      x0;
        fixed_t      y0;
    } fractal_params_t;

    // x0 = 1.0 in Q4.28
    localparam fractal_params_t FRACTAL_PARAMS_INIT = '{
        width:  16'd384,
        height: 16'd216,
        cr:     32'hF9999999,
        ci:     32'h09999999,
        dx:     32'h00155555,
        dy:     32'h00155555,
        x0:     32'sd1 <<< FRAC_BITS,
        y0:     32'h09000000
    };

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_RUN,
        ST_PENDING,
        ST_RESYNC
    } seq_state_e;

    // A geometry change needs the generator restarted; other fields do not.
    function automatic logic size_changed(input fractal_params_t a, input fractal_params_t b);
        return (a.width != b.width) || (a.height != b.height);
    endfunction

endpackage

// File: rtl/fractal_param_sequencer_if.sv
// Host-side parameter update handshake: valid/ready plus the full set.
interface fractal_param_sequencer_if;
    import fractal_pkg::*;

    logic            s_valid;
    logic            s_ready;
    fractal_params_t s_params;

    modport master (output s_valid, output s_params, input s_ready);
    modport slave  (input s_valid, input s_params, output s_ready);

endinterface

// File: rtl/fractal_anim_step.sv
// One bounce step of the cr animation. Computes cr +/- CR_STEP in 33 bits
// so the overshoot past either bound is visible, then clamps to the bound
// and reverses direction. dir_down=0 means increasing.
module fractal_anim_step
    import fractal_pkg::*;
#(
    parameter logic [31:0] CR_STEP = 32'h00020000,
    parameter logic [31:0] CR_MIN  = 32'hF8000000,
    parameter logic [31:0] CR_MAX  = 32'h08000000
) (
    input  fixed_t cr,
    input  logic   dir_down,
    output fixed_t cr_next,
    output logic   dir_down_next
);

    logic signed [32:0] step_w;
    logic signed [32:0] lo_w;
    logic signed [32:0] hi_w;
    logic signed [32:0] sum_w;

    // Sign-extended step, clamp against bounds, flip direction on a hit
    always_comb begin
        step_w        = {CR_STEP[31], CR_STEP};
        lo_w          = {CR_MIN[31], CR_MIN};
        hi_w          = {CR_MAX[31], CR_MAX};
        sum_w         = dir_down ? ({cr[31], cr} - step_w) : ({cr[31], cr} + step_w);
        cr_next       = sum_w[31:0];
        dir_down_next = dir_down;
        if (sum_w > hi_w) begin
            cr_next       = CR_MAX;
            dir_down_next = 1'b1;
        end else if (sum_w < lo_w) begin
            cr_next       = CR_MIN;
            dir_down_next = 1'b0;
        end
    end

endmodule

// File: rtl/fractal_param_sequencer.sv
// Fractal parameter sequencer. Holds the generator in reset after power-up,
// accepts one host parameter set at a time into a shadow copy and applies
// it only on a frame boundary, restarting the generator when the image
// size changes. Optional cr bounce animation is built only when
// FRACTAL_SEQ_ANIM_EN is defined; otherwise cr only changes on host updates.
module fractal_param_sequencer
    import fractal_pkg::*;
#(
    parameter int unsigned RST_HOLD = 4,
    parameter logic [31:0] CR_STEP  = 32'h00020000,
    parameter logic [31:0] CR_MIN   = 32'hF8000000,
    parameter logic [31:0] CR_MAX   = 32'h08000000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      frame_start,
    fractal_param_sequencer_if.slave  s_if,
    output fractal_params_t           params,
    output logic                      gen_resetn,
    output logic [31:0]               frame_count
);

    localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_HOLD - 1);

    // Elaboration-time guard against unusable configurations
    if (($signed(CR_MIN) >= $signed(CR_MAX)) || (RST_HOLD == 0)) begin : g_bad_cfg
        $error("fractal_param_sequencer: CR_MIN must be below CR_MAX and RST_HOLD nonzero");
    end

    seq_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            gen_resetn_q, gen_resetn_d;
    fractal_params_t params_q, params_d;
    fractal_params_t shadow_q, shadow_d;
    logic [31:0]     frame_count_q, frame_count_d;

`ifdef FRACTAL_SEQ_ANIM_EN
    logic   dir_down_q, dir_down_d;
    fixed_t anim_cr;
    logic   anim_dir_down;

    fractal_anim_step #(
        .CR_STEP (CR_STEP),
        .CR_MIN  (CR_MIN),
        .CR_MAX  (CR_MAX)
    ) u_anim (
        .cr            (params_q.cr),
        .dir_down      (dir_down_q),
        .cr_next       (anim_cr),
        .dir_down_next (anim_dir_down)
    );
`endif

    // Host may only hand over a new set while nothing is pending
    assign s_if.s_ready = (state_q == ST_RUN);

    // Next-state and datapath: reset hold, handshake, frame-boundary apply
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gen_resetn_d  = gen_resetn_q;
        params_d      = params_q;
        shadow_d      = shadow_q;
        frame_count_d = frame_count_q;
`ifdef FRACTAL_SEQ_ANIM_EN
        dir_down_d    = dir_down_q;
`endif
        unique case (state_q)
            ST_STARTUP, ST_RESYNC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = ST_RUN;
                    gen_resetn_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (frame_start) begin
                    frame_count_d = frame_count_q + 32'd1;
`ifdef FRACTAL_SEQ_ANIM_EN
                    params_d.cr   = anim_cr;
                    dir_down_d    = anim_dir_down;
`endif
                end
                // A set arriving with frame_start waits for the next frame
                if (s_if.s_valid) begin
                    shadow_d = s_if.s_params;
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    frame_count_d = frame_count_q + 32'd1;
                    params_d      = shadow_q;
`ifdef FRACTAL_SEQ_ANIM_EN
                    dir_down_d    = 1'b0;
`endif
                    if (size_changed(shadow_q, params_q)) begin
                        state_d      = ST_RESYNC;
                        gen_resetn_d = 1'b0;
                        cnt_d        = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d      = ST_STARTUP;
                gen_resetn_d = 1'b0;
                cnt_d        = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_STARTUP;
            cnt_q         <= '0;
            gen_resetn_q  <= 1'b0;
            params_q      <= FRACTAL_PARAMS_INIT;
            shadow_q      <= '0;
            frame_count_q <= '0;
`ifdef FRACTAL_SEQ_ANIM_EN
            dir_down_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gen_resetn_q  <= gen_resetn_d;
            params_q      <= params_d;
            shadow_q      <= shadow_d;
            frame_count_q <= frame_count_d;
`ifdef FRACTAL_SEQ_ANIM_EN
            dir_down_q    <= dir_down_d;
`endif
        end
    end

    assign params      = params_q;
    assign gen_resetn  = gen_resetn_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fractal_param_sequencer.sv
// Bench for fractal_param_sequencer. A small reference model predicts the
// parameter set and frame count for each frame_start; predictions go to a
// scoreboard queue and are popped when the registered outputs settle.
module tb_fractal_param_sequencer;
    import fractal_pkg::*;

`ifdef FRACTAL_SEQ_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic            frame_start = 1'b0;
    fractal_params_t params;
    logic            gen_resetn;
    logic [31:0]     frame_count;

    fractal_param_sequencer_if sif ();

    fractal_param_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .s_if        (sif),
        .params      (params),
        .gen_resetn  (gen_resetn),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        fractal_params_t p;
        logic [31:0]     cnt;
    } exp_t;

    exp_t            sb[$];
    fractal_params_t m_params, m_shadow;
    bit              m_dir_down, m_pending;
    logic [31:0]     m_count;
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic model_reset();
        m_params   = FRACTAL_PARAMS_INIT;
        m_shadow   = '0;
        m_dir_down = 1'b0;
        m_pending  = 1'b0;
        m_count    = '0;
        sb.delete();
    endtask

    task automatic model_animate();
        longint n, hi, lo;
        hi = 64'sh0000_0000_0800_0000;
        lo = -64'sh0000_0000_0800_0000;
        n  = longint'($signed(m_params.cr)) + (m_dir_down ? -64'sh20000 : 64'sh20000);
        if (n > hi) begin
            m_params.cr = 32'h08000000;
            m_dir_down  = 1'b1;
        end else if (n < lo) begin
            m_params.cr = 32'hF8000000;
            m_dir_down  = 1'b0;
        end else begin
            m_params.cr = n[31:0];
        end
    endtask

    task automatic model_frame();
        exp_t e;
        m_count = m_count + 32'd1;
        if (m_pending) begin
            m_params   = m_shadow;
            m_dir_down = 1'b0;
            m_pending  = 1'b0;
        end else if (ANIM) begin
            model_animate();
        end
        e.p   = m_params;
        e.cnt = m_count;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic pulse_frame();
        frame_start = 1'b1;
        model_frame();
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic host_send(input fractal_params_t p);
        sif.s_valid  = 1'b1;
        sif.s_params = p;
        m_shadow     = p;
        m_pending    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.s_valid  = 1'b0;
    endtask

    task automatic test_reset();
        int lows;
        #2 resetn = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (gen_resetn !== 1'b0 || sif.s_ready !== 1'b0 || frame_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got gen_resetn=%b s_ready=%b count=%0d want 0/0/0",
                     gen_resetn, sif.s_ready, frame_count);
        end
        n_cmp++;
        if (params !== FRACTAL_PARAMS_INIT) begin
            n_bad++;
            $display("FAIL reset_params: got %h want %h", params, FRACTAL_PARAMS_INIT);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 20 && gen_resetn !== 1'b1; i++) begin
            lows++;
            @(negedge clk);
        end
        n_cmp++;
        if (lows !== 4) begin
            n_bad++;
            $display("FAIL startup_hold: got %0d low cycles want 4", lows);
        end
        n_cmp++;
        if (sif.s_ready !== 1'b1 || frame_count !== 32'd0 || params !== FRACTAL_PARAMS_INIT) begin
            n_bad++;
            $display("FAIL startup_run: got s_ready=%b count=%0d params=%h want 1/0/%h",
                     sif.s_ready, frame_count, params, FRACTAL_PARAMS_INIT);
        end
    endtask

    task automatic test_animation();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            e = sb.pop_front();
            n_cmp++;
            if (params !== e.p || frame_count !== e.cnt) begin
                n_bad++;
                $display("FAIL anim_frame%0d: got cr=%h count=%0d want cr=%h count=%0d",
                         i, params.cr, frame_count, e.p.cr, e.cnt);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (params.cr !== (ANIM ? 32'hF99F9999 : 32'hF9999999) || frame_count !== 32'd3) begin
            n_bad++;
            $display("FAIL anim_total: got cr=%h count=%0d want cr=%h count=3",
                     params.cr, frame_count, ANIM ? 32'hF99F9999 : 32'hF9999999);
        end
    endtask

    task automatic test_bounce();
        fractal_params_t p;
        exp_t e;
        logic [31:0] want_cr [3];
        want_cr[0] = 32'h07FF0000;
        want_cr[1] = ANIM ? 32'h08000000 : 32'h07FF0000;
        want_cr[2] = ANIM ? 32'h07FE0000 : 32'h07FF0000;
        p    = m_params;
        p.cr = 32'h07FF0000;
        host_send(p);
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            e = sb.pop_front();
            n_cmp++;
            if (params !== e.p || frame_count !== e.cnt || params.cr !== want_cr[i]) begin
                n_bad++;
                $display("FAIL bounce_frame%0d: got cr=%h count=%0d want cr=%h (model %h) count=%0d",
                         i, params.cr, frame_count, want_cr[i], e.p.cr, e.cnt);
            end
        end
    endtask

    task automatic test_host_same_size();
        fractal_params_t p, junk;
        logic [31:0] old_ci;
        exp_t e;
        old_ci = params.ci;
        p      = m_params;
        p.ci   = 32'h0;
        n_cmp++;
        if (sif.s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL same_ready_before: got %b want 1", sif.s_ready);
        end
        host_send(p);
        n_cmp++;
        if (sif.s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL same_ready_after: got %b want 0", sif.s_ready);
        end
        // Offers while not ready must be ignored
        junk         = p;
        junk.ci      = 32'h5;
        sif.s_valid  = 1'b1;
        sif.s_params = junk;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (params.ci !== old_ci || gen_resetn !== 1'b1) begin
                n_bad++;
                $display("FAIL same_hold%0d: got ci=%h gen_resetn=%b want ci=%h gen_resetn=1",
                         i, params.ci, gen_resetn, old_ci);
            end
        end
        sif.s_valid = 1'b0;
        pulse_frame();
        e = sb.pop_front();
        n_cmp++;
        if (params !== e.p || frame_count !== e.cnt || params.ci !== 32'h0) begin
            n_bad++;
            $display("FAIL same_apply: got ci=%h count=%0d want ci=0 count=%0d", params.ci, frame_count, e.cnt);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (gen_resetn !== 1'b1 || sif.s_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL same_no_resync%0d: got gen_resetn=%b s_ready=%b want 1/1", i, gen_resetn, sif.s_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_resync();
        fractal_params_t p;
        exp_t e;
        int lows;
        p       = m_params;
        p.width = 16'd768;
        host_send(p);
        pulse_frame();
        e = sb.pop_front();
        n_cmp++;
        if (params !== e.p || frame_count !== e.cnt || params.width !== 16'd768) begin
            n_bad++;
            $display("FAIL resync_apply: got width=%0d count=%0d want width=768 count=%0d",
                     params.width, frame_count, e.cnt);
        end
        n_cmp++;
        if (sif.s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL resync_ready: got %b want 0", sif.s_ready);
        end
        lows = 0;
        for (int i = 0; i < 20 && gen_resetn !== 1'b1; i++) begin
            lows++;
            frame_start = (i == 1);
            @(negedge clk);
        end
        frame_start = 1'b0;
        n_cmp++;
        if (lows !== 4) begin
            n_bad++;
            $display("FAIL resync_hold: got %0d low cycles want 4", lows);
        end
        n_cmp++;
        if (frame_count !== m_count || params !== m_params || sif.s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL resync_ignore: got count=%0d s_ready=%b want count=%0d s_ready=1",
                     frame_count, sif.s_ready, m_count);
        end
    endtask

    task automatic test_back_to_back();
        fractal_params_t p;
        exp_t e;
        p    = m_params;
        p.cr = 32'h0;
        p.ci = 32'h01000000;
        frame_start  = 1'b1;
        sif.s_valid  = 1'b1;
        sif.s_params = p;
        model_frame();
        m_shadow  = p;
        m_pending = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        sif.s_valid = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (params !== e.p || frame_count !== e.cnt || sif.s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_frame: got cr=%h ci=%h count=%0d s_ready=%b want cr=%h ci=%h count=%0d s_ready=0",
                     params.cr, params.ci, frame_count, sif.s_ready, e.p.cr, e.p.ci, e.cnt);
        end
        @(negedge clk);
        pulse_frame();
        e = sb.pop_front();
        n_cmp++;
        if (params !== e.p || params.cr !== 32'h0 || params.ci !== 32'h01000000) begin
            n_bad++;
            $display("FAIL b2b_apply: got cr=%h ci=%h want cr=0 ci=01000000", params.cr, params.ci);
        end
    endtask

    task automatic test_reset_pending();
        fractal_params_t p;
        exp_t e;
        int waits;
        p    = m_params;
        p.ci = 32'h0ABC0000;
        host_send(p);
        resetn = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (params !== FRACTAL_PARAMS_INIT || frame_count !== 32'd0 || gen_resetn !== 1'b0) begin
            n_bad++;
            $display("FAIL rstpend_async: got params=%h count=%0d gen_resetn=%b want init/0/0",
                     params, frame_count, gen_resetn);
        end
        @(negedge clk);
        resetn = 1'b1;
        waits = 0;
        for (int i = 0; i < 20 && gen_resetn !== 1'b1; i++) begin
            waits++;
            @(negedge clk);
        end
        n_cmp++;
        if (waits !== 4) begin
            n_bad++;
            $display("FAIL rstpend_hold: got %0d low cycles want 4", waits);
        end
        pulse_frame();
        e = sb.pop_front();
        n_cmp++;
        if (params !== e.p || frame_count !== 32'd1 || params.ci !== 32'h09999999) begin
            n_bad++;
            $display("FAIL rstpend_discard: got ci=%h cr=%h count=%0d want ci=09999999 cr=%h count=1",
                     params.ci, params.cr, frame_count, e.p.cr);
        end
    endtask

    initial begin
        sif.s_valid  = 1'b0;
        sif.s_params = '0;
        test_reset();
        test_animation();
        test_bounce();
        test_host_same_size();
        test_resync();
        test_back_to_back();
        test_reset_pending();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
